// File: rtl/mirfak_alu_arbiter_pkg.sv
// mirfak_alu_arbiter_pkg
//   Shared types and widths for the mirfak ALU arbiter and the mirfak_alu it
//   feeds. The control word is
//   {alu_op[1:0], compare_op, shift_op[1:0], logic_op[1:0], adder_op}.
//   The packed struct below mirrors that layout bit for bit:
//     adder_op   = bit 0
//     logic_op   = bits 2:1
//     shift_op   = bits 4:3
//     compare_op = bit 5
//     alu_op     = bits 7:6
package mirfak_alu_arbiter_pkg;

  localparam int DATA_W     = 32;
  localparam int ALU_CTRL_W = 8;

  typedef enum logic [1:0] {
    ALU_OP_ADDER   = 2'd0,
    ALU_OP_LOGIC   = 2'd1,
    ALU_OP_SHIFT   = 2'd2,
    ALU_OP_COMPARE = 2'd3
  } alu_op_e;

  typedef enum logic {
    COMPARE_SLT  = 1'b0,  // signed less-than
    COMPARE_SLTU = 1'b1   // unsigned less-than
  } compare_op_e;

  typedef enum logic [1:0] {
    SHIFT_OP_SLL = 2'd0,
    SHIFT_OP_SRL = 2'd1,
    SHIFT_OP_SRA = 2'd2,
    SHIFT_OP_ROL = 2'd3
  } shift_op_e;

  typedef enum logic [1:0] {
    LOGIC_OP_AND = 2'd0,
    LOGIC_OP_OR  = 2'd1,
    LOGIC_OP_XOR = 2'd2,
    LOGIC_OP_NOR = 2'd3
  } logic_op_e;

  typedef enum logic {
    ADDER_OP_ADD = 1'b0,
    ADDER_OP_SUB = 1'b1
  } adder_op_e;

  typedef struct packed {
    alu_op_e     alu_op;
    compare_op_e compare_op;
    shift_op_e   shift_op;
    logic_op_e   logic_op;
    adder_op_e   adder_op;
  } alu_ctrl_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/mirfak_alu_arbiter_if.sv
// mirfak_alu_arbiter_if
//   Bundles both requester channels and the shared response data bus.
//   Signal suffixes are taken from the arbiter's point of view (_i into the
//   arbiter, _o out of it).
//   Per port N (0 = execute stage, 1 = secondary unit):
//     reqN_valid_i / reqN_ready_o                  request handshake
//     reqN_opa_i / reqN_opb_i / reqN_ctrl_i        operands and control word
//     rspN_valid_o / rspN_ready_i                  response handshake
//   rsp_data_o is the shared result, qualified by rsp0_valid_o / rsp1_valid_o.
//   modport master : requester side
//   modport slave  : arbiter side
interface mirfak_alu_arbiter_if;
  import mirfak_alu_arbiter_pkg::*;

  logic                  req0_valid_i;
  logic                  req0_ready_o;
  logic [DATA_W-1:0]     req0_opa_i;
  logic [DATA_W-1:0]     req0_opb_i;
  logic [ALU_CTRL_W-1:0] req0_ctrl_i;
  logic                  rsp0_valid_o;
  logic                  rsp0_ready_i;

  logic                  req1_valid_i;
  logic                  req1_ready_o;
  logic [DATA_W-1:0]     req1_opa_i;
  logic [DATA_W-1:0]     req1_opb_i;
  logic [ALU_CTRL_W-1:0] req1_ctrl_i;
  logic                  rsp1_valid_o;
  logic                  rsp1_ready_i;

  logic [DATA_W-1:0]     rsp_data_o;

  modport master (
    output req0_valid_i, req0_opa_i, req0_opb_i, req0_ctrl_i, rsp0_ready_i,
    output req1_valid_i, req1_opa_i, req1_opb_i, req1_ctrl_i, rsp1_ready_i,
    input  req0_ready_o, rsp0_valid_o, req1_ready_o, rsp1_valid_o, rsp_data_o
  );

  modport slave (
    input  req0_valid_i, req0_opa_i, req0_opb_i, req0_ctrl_i, rsp0_ready_i,
    input  req1_valid_i, req1_opa_i, req1_opb_i, req1_ctrl_i, rsp1_ready_i,
    output req0_ready_o, rsp0_valid_o, req1_ready_o, rsp1_valid_o, rsp_data_o
  );

endinterface

// File: rtl/mirfak_alu.sv
// mirfak_alu
//   Purely combinational ALU. It is shared by the arbiter through a grant mux.
//   Ports:
//     opa_i    in  32  operand A
//     opb_i    in  32  operand B (bits 4:0 give the shift amount for shifts)
//     ctrl_i   in   8  control word, see alu_ctrl_t
//     result_o out 32  result; compares return 0 or 1
module mirfak_alu
  import mirfak_alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]     opa_i,
  input  logic [DATA_W-1:0]     opb_i,
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0]     result_o
);

  alu_ctrl_t  ctrl;
  logic [4:0] shamt;
  logic       lt;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    result_o = '0;
    lt       = 1'b0;
    ctrl     = alu_ctrl_t'(ctrl_i);
    shamt    = opb_i[4:0];
    unique case (ctrl.alu_op)
      ALU_OP_ADDER: begin
        result_o = (ctrl.adder_op == ADDER_OP_SUB) ? opa_i - opb_i : opa_i + opb_i;
      end
      ALU_OP_LOGIC: begin
        unique case (ctrl.logic_op)
          LOGIC_OP_AND: result_o = opa_i & opb_i;
          LOGIC_OP_OR:  result_o = opa_i | opb_i;
          LOGIC_OP_XOR: result_o = opa_i ^ opb_i;
          LOGIC_OP_NOR: result_o = ~(opa_i | opb_i);
        endcase
      end
      ALU_OP_SHIFT: begin
        unique case (ctrl.shift_op)
          SHIFT_OP_SLL: result_o = opa_i << shamt;
          SHIFT_OP_SRL: result_o = opa_i >> shamt;
          SHIFT_OP_SRA: result_o = $signed(opa_i) >>> shamt;
          // With a shift amount of 0 the right-shift term shifts by 32, which
          // gives 0, so the operand passes through unchanged.
          SHIFT_OP_ROL: result_o = (opa_i << shamt) | (opa_i >> (6'd32 - {1'b0, shamt}));
        endcase
      end
      ALU_OP_COMPARE: begin
        lt = (ctrl.compare_op == COMPARE_SLTU) ? (opa_i < opb_i)
                                               : ($signed(opa_i) < $signed(opb_i));
        result_o = {{(DATA_W-1){1'b0}}, lt};
      end
    endcase
  end

endmodule

// File: rtl/mirfak_alu_arbiter.sv
// mirfak_alu_arbiter
//   Lets two requesters share one mirfak_alu. Port 0 is the execute stage and
//   port 1 is the secondary unit (CSR/debug). A request is accepted only when
//   the single result slot is free, meaning it is empty or its owner is
//   consuming it this cycle. The ALU result is registered on the accept edge.
//   The owner's response valid rises one cycle later and is held until the
//   owner consumes it.
//   Ports:
//     clk_i   in  1  core clock
//     rst_i   in  1  synchronous active-high reset
//     bus     slave modport of mirfak_alu_arbiter_if (both channels + rsp data)
//   Parameter:
//     STARVE_LIMIT  cycles port 1 may wait before it is forced to win (1..255)
//   Build option MIRFAK_ALU_ARB_RR_EN:
//     defined   -> round-robin; the last granted port loses on contention
//     undefined -> port 0 has priority; a starvation counter eventually
//                  forces a win for port 1
module mirfak_alu_arbiter
  import mirfak_alu_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  mirfak_alu_arbiter_if.slave bus
);

  logic                  slot_free;
  logic                  prefer1;
  logic                  grant0;
  logic                  grant1;
  logic [DATA_W-1:0]     alu_opa;
  logic [DATA_W-1:0]     alu_opb;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0]     alu_res;

  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]     rsp_data_q,   rsp_data_d;

`ifdef MIRFAK_ALU_ARB_RR_EN
  port_e rr_ptr_q, rr_ptr_d;

  // The port that won last time yields on contention.
  assign prefer1 = (rr_ptr_q == PORT0);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant0)      rr_ptr_d = PORT0;
    else if (grant1) rr_ptr_d = PORT1;
  end

  // After reset the pointer shows port 1, so port 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= PORT1;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign prefer1 = (starve_cnt_q == STARVE_MAX);

  // Counts cycles in which port 1 is waiting, including cycles where the slot
  // is busy. The count saturates at the limit and clears on a port 1 grant or
  // when port 1 drops its request.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.req1_valid_i && !grant1) begin
      starve_cnt_d = prefer1 ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`endif

  // Grant logic. Readys are forced low while reset is held.
  always_comb begin
    slot_free = !(rsp0_valid_q || rsp1_valid_q)
              || (rsp0_valid_q && bus.rsp0_ready_i)
              || (rsp1_valid_q && bus.rsp1_ready_i);
    grant1 = !rst_i && slot_free && bus.req1_valid_i && (!bus.req0_valid_i || prefer1);
    grant0 = !rst_i && slot_free && bus.req0_valid_i && !grant1;
  end

  assign alu_opa  = grant1 ? bus.req1_opa_i  : bus.req0_opa_i;
  assign alu_opb  = grant1 ? bus.req1_opb_i  : bus.req0_opb_i;
  assign alu_ctrl = grant1 ? bus.req1_ctrl_i : bus.req0_ctrl_i;

  mirfak_alu u_alu (
    .opa_i   (alu_opa),
    .opb_i   (alu_opb),
    .ctrl_i  (alu_ctrl),
    .result_o(alu_res)
  );

  // A consume and a new grant can happen on the same edge. In that case the
  // new result replaces the old one and valid moves to the new owner with no
  // bubble cycle in between.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q && !bus.rsp0_ready_i;
    rsp1_valid_d = rsp1_valid_q && !bus.rsp1_ready_i;
    rsp_data_d   = rsp_data_q;
    if (grant0 || grant1) begin
      rsp0_valid_d = grant0;
      rsp1_valid_d = grant1;
      rsp_data_d   = alu_res;
    end
  end

  // NOTE: state is updated only with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;
  assign bus.rsp0_valid_o = rsp0_valid_q;
  assign bus.rsp1_valid_o = rsp1_valid_q;
  assign bus.rsp_data_o   = rsp_data_q;

endmodule

// File: tb/tb_mirfak_alu_arbiter.sv
// tb_mirfak_alu_arbiter
//   Self-checking bench for mirfak_alu_arbiter. A behavioural model tracks
//   three things: the owner of the result slot, the value it holds, and how
//   long port 1 has been waiting. Every cycle the DUT's readys, response
//   valids and data are compared against that model. Directed scenarios add
//   literal expectations, and a randomized phase follows them.
module tb_mirfak_alu_arbiter;

  localparam int STARVE_LIMIT = 8;
`ifdef MIRFAK_ALU_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif
  localparam logic [7:0] CTRL_ADD = 8'h00;
  localparam logic [7:0] CTRL_SUB = 8'h01;
  localparam logic [7:0] CTRL_SRA = 8'h90;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mirfak_alu_arbiter_if bus ();

  mirfak_alu_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Values to drive in the next cycle.
  logic        drv_rst;
  logic        drv_v  [2];
  logic [31:0] drv_a  [2];
  logic [31:0] drv_b  [2];
  logic [7:0]  drv_c  [2];
  logic        drv_rr [2];

  // Model state: slot owner (-1 = empty), held result, port 1 wait time,
  // last granted port, and the winner of the most recent cycle.
  int          m_owner  = -1;
  logic [31:0] m_data   = '0;
  int          m_wait1  = 0;
  int          m_last   = 1;
  int          m_winner = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written directly from the field definitions.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [7:0] c);
    int sh;
    sh = int'(b[4:0]);
    case (c[7:6])
      2'd0: return c[0] ? a - b : a + b;
      2'd1: case (c[2:1])
              2'd0:    return a & b;
              2'd1:    return a | b;
              2'd2:    return a ^ b;
              default: return ~(a | b);
            endcase
      2'd2: case (c[4:3])
              2'd0:    return a << sh;
              2'd1:    return a >> sh;
              2'd2:    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
              default: return (a << sh) | (a >> (32 - sh));
            endcase
      default: begin
        if (c[5]) return (a < b) ? 32'd1 : 32'd0;
        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
    endcase
  endfunction

  // One clock cycle. Inputs are applied on the falling edge and outputs are
  // compared 1 ns later. The model then moves to the state it should have
  // after the next rising edge.
  task automatic cycle();
    int w;
    @(negedge clk);
    rst              = drv_rst;
    bus.req0_valid_i = drv_v[0];
    bus.req0_opa_i   = drv_a[0];
    bus.req0_opb_i   = drv_b[0];
    bus.req0_ctrl_i  = drv_c[0];
    bus.rsp0_ready_i = drv_rr[0];
    bus.req1_valid_i = drv_v[1];
    bus.req1_opa_i   = drv_a[1];
    bus.req1_opb_i   = drv_b[1];
    bus.req1_ctrl_i  = drv_c[1];
    bus.rsp1_ready_i = drv_rr[1];
    #1;
    w = -1;
    if (!drv_rst && (m_owner < 0 || drv_rr[m_owner])) begin
      if (drv_v[0] && drv_v[1])
        w = RR_MODE ? ((m_last == 0) ? 1 : 0) : ((m_wait1 >= STARVE_LIMIT) ? 1 : 0);
      else if (drv_v[1]) w = 1;
      else if (drv_v[0]) w = 0;
    end
    m_winner = w;
    check("req0_ready", {31'b0, bus.req0_ready_o}, {31'b0, w == 0});
    check("req1_ready", {31'b0, bus.req1_ready_o}, {31'b0, w == 1});
    check("rsp0_valid", {31'b0, bus.rsp0_valid_o}, {31'b0, m_owner == 0});
    check("rsp1_valid", {31'b0, bus.rsp1_valid_o}, {31'b0, m_owner == 1});
    if (m_owner >= 0) check("rsp_data", bus.rsp_data_o, m_data);
    if (drv_rst) begin
      m_owner = -1;
      m_data  = '0;
      m_wait1 = 0;
      m_last  = 1;
    end else begin
      if (w >= 0) begin
        m_owner = w;
        m_data  = alu_ref(drv_a[w], drv_b[w], drv_c[w]);
        m_last  = w;
      end else if (m_owner >= 0 && drv_rr[m_owner]) begin
        m_owner = -1;
      end
      if (drv_v[1] && w != 1) m_wait1 = (m_wait1 < STARVE_LIMIT) ? m_wait1 + 1 : m_wait1;
      else                    m_wait1 = 0;
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] c);
    drv_v[p] = 1'b1;
    drv_a[p] = a;
    drv_b[p] = b;
    drv_c[p] = c;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 2; p++) begin
      drv_v[p]  = 1'b0;
      drv_a[p]  = '0;
      drv_b[p]  = '0;
      drv_c[p]  = '0;
      drv_rr[p] = 1'b1;
    end
  endtask

  task automatic do_reset();
    idle_all();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
  endtask

  task automatic rand_req(input int p);
    set_req(p, $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            8'($urandom_range(0, 255)));
  endtask

  initial begin
    idle_all();
    drv_rst = 1'b1;
    rst     = 1'b1;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    bus.req0_opa_i = '0; bus.req0_opb_i = '0; bus.req0_ctrl_i = '0;
    bus.req1_opa_i = '0; bus.req1_opb_i = '0; bus.req1_ctrl_i = '0;
    repeat (2) @(posedge clk);

    // Reset held with both requests valid: nothing is granted and the outputs
    // stay cleared. Port 0 wins on the first cycle after release.
    set_req(0, 32'd1, 32'd2, CTRL_ADD);
    set_req(1, 32'd3, 32'd4, CTRL_ADD);
    drv_rr[0] = 1'b0;
    drv_rr[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_req0_ready", {31'b0, bus.req0_ready_o}, 32'd0);
      check("rst_req1_ready", {31'b0, bus.req1_ready_o}, 32'd0);
      check("rst_rsp0_valid", {31'b0, bus.rsp0_valid_o}, 32'd0);
      check("rst_rsp1_valid", {31'b0, bus.rsp1_valid_o}, 32'd0);
      check("rst_rsp_data", bus.rsp_data_o, 32'd0);
    end
    drv_rst = 1'b0;
    cycle();
    check("first_grant_p0", {31'b0, bus.req0_ready_o}, 32'd1);
    check("first_grant_p1", {31'b0, bus.req1_ready_o}, 32'd0);

    // Port 0 back-to-back ADDs.
    do_reset();
    set_req(0, 32'd5, 32'd7, CTRL_ADD);
    cycle();
    check("add_accept", {31'b0, bus.req0_ready_o}, 32'd1);
    set_req(0, 32'd1, 32'd1, CTRL_ADD);
    cycle();
    check("add_5_7_valid", {31'b0, bus.rsp0_valid_o}, 32'd1);
    check("add_5_7_data", bus.rsp_data_o, 32'd12);
    check("add_b2b_accept", {31'b0, bus.req0_ready_o}, 32'd1);
    drv_v[0] = 1'b0;
    cycle();
    check("add_1_1_valid", {31'b0, bus.rsp0_valid_o}, 32'd1);
    check("add_1_1_data", bus.rsp_data_o, 32'd2);
    cycle();
    check("add_drained", {31'b0, bus.rsp0_valid_o}, 32'd0);

    // Port 1 SUB held while its owner stalls. Both ports are blocked until
    // the consume cycle.
    do_reset();
    drv_rr[1] = 1'b0;
    set_req(1, 32'd3, 32'd5, CTRL_SUB);
    cycle();
    check("sub_accept", {31'b0, bus.req1_ready_o}, 32'd1);
    set_req(0, 32'd2, 32'd2, CTRL_ADD);
    set_req(1, 32'd10, 32'd20, CTRL_ADD);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("sub_hold_valid", {31'b0, bus.rsp1_valid_o}, 32'd1);
      check("sub_hold_data", bus.rsp_data_o, 32'hFFFF_FFFE);
      check("hold_req0_ready", {31'b0, bus.req0_ready_o}, 32'd0);
      check("hold_req1_ready", {31'b0, bus.req1_ready_o}, 32'd0);
    end
    drv_rr[1] = 1'b1;
    cycle();
    check("consume_grant_p0", {31'b0, bus.req0_ready_o}, 32'd1);
    drv_v[0] = 1'b0;
    cycle();
    check("switch_rsp0_valid", {31'b0, bus.rsp0_valid_o}, 32'd1);
    check("switch_rsp1_valid", {31'b0, bus.rsp1_valid_o}, 32'd0);
    check("switch_data", bus.rsp_data_o, 32'd4);

    // Continuous contention. The arbiter should grant port 1 every
    // STARVE_LIMIT+1 cycles in fixed-priority mode, and on every other cycle
    // in round-robin mode.
    do_reset();
    set_req(0, 32'd100, 32'd1, CTRL_ADD);
    set_req(1, 32'd200, 32'd2, CTRL_SUB);
    for (int k = 1; k <= 20; k++) begin
      logic exp1;
      cycle();
      exp1 = RR_MODE ? (k % 2 == 0) : (k % (STARVE_LIMIT + 1) == 0);
      check("contention_grant1", {31'b0, bus.req1_ready_o}, {31'b0, exp1});
      check("contention_grant0", {31'b0, bus.req0_ready_o}, {31'b0, !exp1});
      if (m_winner >= 0) rand_req(m_winner);
    end

    // Arithmetic right shift.
    do_reset();
    set_req(0, 32'h8000_0000, 32'd4, CTRL_SRA);
    cycle();
    drv_v[0] = 1'b0;
    cycle();
    check("sra_data", bus.rsp_data_o, 32'hF800_0000);

    // Reset while a port 1 result is pending.
    do_reset();
    drv_rr[1] = 1'b0;
    set_req(1, 32'd9, 32'd4, CTRL_SUB);
    cycle();
    drv_v[1] = 1'b0;
    cycle();
    check("pend_rsp1_valid", {31'b0, bus.rsp1_valid_o}, 32'd1);
    check("pend_rsp1_data", bus.rsp_data_o, 32'd5);
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_rst_rsp1_valid", {31'b0, bus.rsp1_valid_o}, 32'd0);
      check("post_rst_rsp0_valid", {31'b0, bus.rsp0_valid_o}, 32'd0);
    end

    // Randomized traffic. A requester holds its request until the model says
    // it was accepted.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!drv_v[p] || m_winner == p) begin
          if ($urandom_range(0, 9) < 6) rand_req(p);
          else                          drv_v[p] = 1'b0;
        end
        drv_rr[p] = ($urandom_range(0, 3) != 0);
      end
      drv_rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
